// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter for the shared spike/filter/mempot memory port, with fixed-latency reads and timestep barrier.
// Optional WRITE_ACK_EN: writes also pass through RESP and pulse rsp_valid with zero data.
module mem_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int X_W       = 3,
    parameter int Y_W       = 3,
    parameter int MEM_LAT   = 3,
    parameter int TIMESTEPS = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [2*NUM_REQ-1:0]      req_sel,
    input  logic [X_W*NUM_REQ-1:0]    req_x,
    input  logic [Y_W*NUM_REQ-1:0]    req_y,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [1:0]                mem_sel,
    output logic [X_W-1:0]            mem_x,
    output logic [Y_W-1:0]            mem_y,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      ts_adv_valid,
    output logic                      ts_adv_ready,
    output logic                      mem_t_adv,
    output logic [3:0]                ts_cur,
    output logic                      done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int LW = $clog2(MEM_LAT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, TADV} state_t;
`ifdef WRITE_ACK_EN
    localparam state_t WR_NEXT = RESP;
`else
    localparam state_t WR_NEXT = IDLE;
`endif
    state_t state_q, state_d;
    logic [IW-1:0] rr_q, rr_d, id_q, win, win_hi, win_lo;
    logic [LW-1:0] lat_q, lat_d;
    logic [3:0] ts_q;
    logic done_q, wr_q, found, any_hi, accept, ts_go;
    logic w_we;
    logic [1:0] w_sel;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic [DATA_W-1:0] w_wdata;

    // Lowest valid index at/after the pointer, else lowest overall (wrap).
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        any_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) win_lo = IW'(i);
            if (req_valid[i] && IW'(i) >= rr_q) begin
                win_hi = IW'(i);
                any_hi = 1'b1;
            end
        end
        win = any_hi ? win_hi : win_lo;
    end

    always_comb begin
        w_we = 1'b0;
        w_sel = '0;
        w_x = '0;
        w_y = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == win) begin
                w_we = req_we[i];
                w_sel = req_sel[2*i +: 2];
                w_x = req_x[X_W*i +: X_W];
                w_y = req_y[Y_W*i +: Y_W];
                w_wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign found  = |req_valid;
    assign ts_go  = ts_adv_valid && !done_q;
    assign accept = (state_q == IDLE) && found && !ts_go;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        lat_d = lat_q;
        rr_d = rr_q;
        case (state_q)
            IDLE: begin
                if (ts_go) state_d = TADV;
                else if (found) begin
                    state_d = ISSUE;
                    rr_d = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                end
            end
            ISSUE: begin
                if (wr_q) state_d = WR_NEXT;
                else if (MEM_LAT == 1) state_d = RESP;
                else begin
                    state_d = WAIT;
                    lat_d = LW'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == LW'(1)) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // mem_* are loaded on accept so they line up exactly with ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q <= '0;
            lat_q <= '0;
            id_q <= '0;
            wr_q <= 1'b0;
            ts_q <= 4'd1;
            done_q <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_sel <= '0;
            mem_x <= '0;
            mem_y <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            lat_q <= lat_d;
            mem_en <= accept;
            mem_we <= accept & w_we;
            mem_wdata <= accept ? w_wdata : '0;
            if (accept) begin
                id_q <= win;
                wr_q <= w_we;
                mem_sel <= w_sel;
                mem_x <= w_x;
                mem_y <= w_y;
            end
            if (state_q == TADV) begin
                if (ts_q == 4'(TIMESTEPS)) done_q <= 1'b1;
                else ts_q <= ts_q + 4'd1;
            end
        end
    end

    assign rsp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << id_q) : '0;
    assign rsp_data     = (state_q == RESP && !wr_q) ? mem_rdata : '0;
    assign ts_adv_ready = (state_q == TADV);
    assign mem_t_adv    = (state_q == TADV);
    assign ts_cur       = ts_q;
    assign done         = done_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized check of mem_req_arbiter against a transaction-planning model, plus directed literal checks.
module tb_mem_req_arbiter;
    localparam int NR = 4, DW = 8, XW = 3, YW = 3, LAT = 3, TS = 10;
    logic clk = 0, rst_n = 0;
    logic [NR-1:0] req_valid, req_ready, req_we, rsp_valid;
    logic [2*NR-1:0] req_sel;
    logic [XW*NR-1:0] req_x;
    logic [YW*NR-1:0] req_y;
    logic [DW*NR-1:0] req_wdata;
    logic mem_en, mem_we, ts_adv_valid, ts_adv_ready, mem_t_adv, done;
    logic [1:0] mem_sel;
    logic [XW-1:0] mem_x;
    logic [YW-1:0] mem_y;
    logic [DW-1:0] mem_wdata, mem_rdata, rsp_data;
    logic [3:0] ts_cur;

    always #5 clk = ~clk;

    mem_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .X_W(XW), .Y_W(YW), .MEM_LAT(LAT), .TIMESTEPS(TS)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sel(req_sel), .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_x(mem_x), .mem_y(mem_y),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ts_adv_valid(ts_adv_valid), .ts_adv_ready(ts_adv_ready), .mem_t_adv(mem_t_adv),
        .ts_cur(ts_cur), .done(done));

    // One planned cycle of expected outputs; an empty plan means the arbiter is free.
    typedef struct {
        logic en, we, tadv;
        logic [1:0] sel;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [DW-1:0] wd, rd;
        logic [NR-1:0] rv;
    } exp_t;
    typedef struct {int t; logic [DW-1:0] d;} due_t;

    exp_t plan[$];
    due_t due[$];
    logic [DW-1:0] mmem[256], emem[256];
    int checks = 0, errors = 0, cyc = 0, m_rr = 0, m_ts = 1;
    bit m_done = 0, rearm = 0, rnd = 0;
    logic [1:0] l_sel;
    logic [XW-1:0] l_x;
    logic [YW-1:0] l_y;
    int glog[$];
    int en_cyc = 0, rsp_cyc = -1, ts_cyc = 0, rsp_cnt = 0, en_cnt = 0, tacks = 0;
    logic [NR-1:0] rsp_v_last;
    logic [DW-1:0] rsp_d_last, en_wd;
    logic en_we;
    logic [1:0] en_sel;
    logic [XW-1:0] en_x;
    logic [YW-1:0] en_y;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        plan.delete();
        due.delete();
        m_rr = 0;
        m_ts = 1;
        m_done = 0;
        l_sel = 0;
        l_x = 0;
        l_y = 0;
    endtask

    task automatic rand_fields(input int i);
        req_we[i] = 1'($urandom_range(1));
        req_sel[2*i +: 2] = 2'($urandom);
        req_x[XW*i +: XW] = XW'($urandom);
        req_y[YW*i +: YW] = YW'($urandom);
        req_wdata[DW*i +: DW] = DW'($urandom);
    endtask

    task automatic check_cycle();
        exp_t e, s, r, z;
        logic [NR-1:0] er;
        logic [7:0] a;
        int w;
        z = '{default: '0};
        e = z;
        er = '0;
        if (plan.size() > 0) e = plan.pop_front();
        else if (ts_adv_valid && !m_done) begin
            s = z;
            s.tadv = 1;
            plan.push_back(s);
        end else if (req_valid != 0) begin
            w = m_rr;
            while (!req_valid[w]) w = (w + 1) % NR;
            er[w] = 1'b1;
            m_rr = (w + 1) % NR;
            s = z;
            s.en = 1;
            s.we = req_we[w];
            s.sel = req_sel[2*w +: 2];
            s.x = req_x[XW*w +: XW];
            s.y = req_y[YW*w +: YW];
            s.wd = req_wdata[DW*w +: DW];
            a = {s.sel, s.x, s.y};
            plan.push_back(s);
            r = z;
            r.rv = er;
            if (s.we) begin
                mmem[a] = s.wd;
`ifdef WRITE_ACK_EN
                plan.push_back(r);
`endif
            end else begin
                repeat (LAT - 1) plan.push_back(z);
                r.rd = mmem[a];
                plan.push_back(r);
            end
        end
        if (e.en) begin
            l_sel = e.sel;
            l_x = e.x;
            l_y = e.y;
        end
        chk("req_ready", req_ready, er);
        chk("mem_en", mem_en, e.en);
        chk("mem_we", mem_we, e.we);
        chk("mem_wdata", mem_wdata, e.wd);
        chk("mem_sel", mem_sel, l_sel);
        chk("mem_x", mem_x, l_x);
        chk("mem_y", mem_y, l_y);
        chk("rsp_valid", rsp_valid, e.rv);
        if (e.rv != 0) chk("rsp_data", rsp_data, e.rd);
        chk("ts_adv_ready", ts_adv_ready, e.tadv);
        chk("mem_t_adv", mem_t_adv, e.tadv);
        chk("ts_cur", ts_cur, m_ts);
        chk("done", done, m_done);
        if (e.tadv) begin
            if (m_ts == TS) m_done = 1;
            else m_ts++;
        end
        for (int i = 0; i < NR; i++) if (req_ready[i] && req_valid[i]) glog.push_back(i);
        if (mem_en) begin
            en_cyc = cyc;
            en_cnt++;
            en_we = mem_we;
            en_sel = mem_sel;
            en_x = mem_x;
            en_y = mem_y;
            en_wd = mem_wdata;
            if (mem_we) emem[{mem_sel, mem_x, mem_y}] = mem_wdata;
            else due.push_back('{cyc + LAT, emem[{mem_sel, mem_x, mem_y}]});
        end
        if (rsp_valid != 0) begin
            rsp_cyc = cyc;
            rsp_cnt++;
            rsp_v_last = rsp_valid;
            rsp_d_last = rsp_data;
        end
        if (ts_adv_ready) begin
            ts_cyc = cyc;
            tacks++;
        end
    endtask

    task automatic step();
        logic [NR-1:0] acc;
        logic tack;
        due_t d;
        @(negedge clk);
        check_cycle();
        acc = req_ready & req_valid;
        tack = ts_adv_ready;
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = DW'($urandom);
        if (due.size() > 0 && due[0].t == cyc) begin
            d = due.pop_front();
            mem_rdata = d.d;
        end
        if (tack) ts_adv_valid = 0;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                req_valid[i] = rearm;
                if (rearm) rand_fields(i);
            end
        end
        if (rnd) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i] = 1;
                    rand_fields(i);
                end else if (req_valid[i] && $urandom_range(63) == 0) req_valid[i] = 0;
            end
            if (!ts_adv_valid && $urandom_range(15) == 0) ts_adv_valid = 1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((plan.size() != 0 || req_valid != 0) && n < 60) begin
            step();
            n++;
        end
        chk("drain_idle", (plan.size() == 0 && req_valid == 0), 1);
    endtask

    initial begin
        int n;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        req_valid = 0;
        req_we = 0;
        req_sel = 0;
        req_x = 0;
        req_y = 0;
        req_wdata = 0;
        ts_adv_valid = 0;
        mem_rdata = 0;
        for (int i = 0; i < 256; i++) begin
            mmem[i] = DW'($urandom);
            emem[i] = mmem[i];
        end
        mmem[8'h82] = 8'h5A;
        emem[8'h82] = 8'h5A;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ts_cur", ts_cur, 1);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1;

        // all four held: grants 0,1,2,3,0
        rearm = 1;
        for (int i = 0; i < NR; i++) rand_fields(i);
        req_valid = '1;
        n = 0;
        while (glog.size() < 5 && n < 100) begin step(); n++; end
        chk("rr_grant_count", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_grant_order", glog[i], exp_g[i]);
        // pointer now 1 with only 0 and 3 held: 3 then 0
        rearm = 0;
        req_valid[1] = 0;
        req_valid[2] = 0;
        glog.delete();
        n = 0;
        while (glog.size() < 2 && n < 60) begin step(); n++; end
        chk("rr_wrap_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("rr_wrap_first", glog[0], 3);
            chk("rr_wrap_second", glog[1], 0);
        end
        drain();

        // single read by requester 1 of mempot (0,2)
        req_we[1] = 0;
        req_sel[3:2] = 2'b10;
        req_x[5:3] = 3'd0;
        req_y[5:3] = 3'd2;
        req_valid[1] = 1;
        rsp_cnt = 0;
        n = 0;
        while (rsp_cnt == 0 && n < 30) begin step(); n++; end
        chk("read_rsp_valid", rsp_v_last, 4'b0010);
        chk("read_rsp_data", rsp_d_last, 8'h5A);
        chk("read_latency", rsp_cyc - en_cyc, LAT);
        drain();

        // write by requester 3 to ofmap (1,1)
        req_we[3] = 1;
        req_sel[7:6] = 2'b11;
        req_x[11:9] = 3'd1;
        req_y[11:9] = 3'd1;
        req_wdata[31:24] = 8'h01;
        req_valid[3] = 1;
        rsp_cnt = 0;
        en_cnt = 0;
        repeat (8) step();
        chk("write_en_count", en_cnt, 1);
        chk("write_we", en_we, 1);
        chk("write_sel", en_sel, 2'b11);
        chk("write_x", en_x, 1);
        chk("write_y", en_y, 1);
        chk("write_wdata", en_wd, 8'h01);
`ifdef WRITE_ACK_EN
        chk("write_rsp_count", rsp_cnt, 1);
        chk("write_rsp_valid", rsp_v_last, 4'b1000);
`else
        chk("write_rsp_count", rsp_cnt, 0);
`endif
        drain();

        // timestep request raised during a read waits for RESP
        glog.delete();
        rsp_cyc = -1;
        tacks = 0;
        req_we[0] = 0;
        req_valid[0] = 1;
        n = 0;
        while (glog.size() == 0 && n < 30) begin step(); n++; end
        ts_adv_valid = 1;
        n = 0;
        while (tacks == 0 && n < 30) begin step(); n++; end
        chk("tadv_after_resp", (rsp_cyc >= 0 && ts_cyc > rsp_cyc), 1);
        chk("tadv_ts_cur", ts_cur, 2);
        drain();

        // async reset mid-WAIT of a read by requester 2
        glog.delete();
        req_we[2] = 0;
        req_valid[2] = 1;
        n = 0;
        while (glog.size() == 0 && n < 30) begin step(); n++; end
        step();
        rst_n = 0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_ts_cur", ts_cur, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        #2;
        rst_n = 1;
        model_reset();
        tacks = 0;
        glog.delete();
        req_valid[2] = 1;
        req_valid[3] = 1;
        n = 0;
        while (glog.size() == 0 && n < 30) begin step(); n++; end
        chk("post_rst_first_grant", glog.size() > 0 ? glog[0] : -1, 2);
        drain();

        // randomized traffic with timestep advances
        rnd = 1;
        repeat (3000) step();
        rnd = 0;
        chk("final_done", done, 1);
        chk("final_ts_cur", ts_cur, TS);
        chk("ts_ack_total", tacks, TS);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Clocked scheduler that shares the single spike/filter/membrane-potential memory port among up to NUM_REQ requesters: filter loader, ifmap reader, mempot reader/writer, ofmap writer.
- Provides round-robin arbitration, fixed-latency read sequencing and response routing back to the originating requester.
- Also owns the timestep barrier: issues the memory "advance timestep" pulse and counts timesteps up to TIMESTEPS.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, memory data width (filter byte / membrane potential)
X_W, 3, row index width
Y_W, 3, column index width
MEM_LAT, 3, cycles from mem_en to valid mem_rdata (>=1)
TIMESTEPS, 10, last timestep value; done asserts after it completes

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid, held until accepted
req_ready  out  NUM_REQ  one-hot accept; handshake completes on valid&ready
req_we  in  NUM_REQ  1=write, 0=read
req_sel  in  2*NUM_REQ  memory select per requester: 00 ifmap, 01 filter, 10 mempot, 11 ofmap
req_x  in  X_W*NUM_REQ  row index per requester
req_y  in  Y_W*NUM_REQ  column index per requester
req_wdata  in  DATA_W*NUM_REQ  write data per requester
mem_en  out  1  memory access strobe, one cycle
mem_we  out  1  write enable qualifying mem_en
mem_sel  out  2  memory select
mem_x  out  X_W  row
mem_y  out  Y_W  column
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en
rsp_valid  out  NUM_REQ  one-hot, one-cycle read response pulse
rsp_data  out  DATA_W  response data, valid with rsp_valid
ts_adv_valid  in  1  request to advance timestep, held until ts_adv_ready
ts_adv_ready  out  1  one-cycle acknowledge
mem_t_adv  out  1  one-cycle advance strobe to memory
ts_cur  out  4  current timestep
done  out  1  sticky, all timesteps complete

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr pointer=0, ts_cur=1, done=0. All other outputs 0. An in-flight transaction is dropped with no rsp_valid. Reset release is sampled on the next clk rising edge.
- IDLE:
  - If ts_adv_valid && !done: go to TADV. Timestep advance has priority over requests.
  - Else if any req_valid: winner = first valid index at or after the rr pointer, wrapping. req_ready[winner]=1 combinationally in this cycle. On the edge, capture we/sel/x/y/wdata and id, set rr pointer=(winner+1) mod NUM_REQ, go to ISSUE.
  - req_ready is 0 in every state other than IDLE.
- ISSUE (1 cycle): mem_en=1; mem_we/sel/x/y/wdata come from captured registers.
  - Write: go to IDLE.
  - Read: go to WAIT with lat_cnt=MEM_LAT-1; if MEM_LAT==1, go directly to RESP.
- WAIT: lat_cnt decrements each cycle. At lat_cnt==1, go to RESP.
- RESP (1 cycle): rsp_valid[id]=1, rsp_data=mem_rdata sampled this cycle. Go to IDLE.
- Read turnaround is 2+MEM_LAT cycles from accept to IDLE. A back-to-back request is accepted in the cycle after RESP.
- TADV (1 cycle): mem_t_adv=1, ts_adv_ready=1. If ts_cur==TIMESTEPS, set done=1 and hold ts_cur; else increment ts_cur. Go to IDLE.
- After done=1: ts_adv_valid is never acknowledged; memory requests are still served.
- ts_adv_valid asserted while in ISSUE/WAIT/RESP: it waits; the current transaction completes first.
- Requests that arrive during a transaction remain pending; round-robin guarantees service within NUM_REQ grants.
- A requester that drops req_valid before it is accepted receives no grant (no error).
- mem_* outputs are registered; they are 0 outside ISSUE except mem_x/mem_y/mem_sel, which hold their last value.

Optional Feature:
WRITE_ACK_EN.
- Defined: a write also passes through RESP. rsp_valid[id] pulses one cycle after ISSUE, with rsp_data=0.
- Undefined: writes produce no response.

Test Plan:
- Reset: rst_n low mid-WAIT of a read by requester 2 -> no rsp_valid, req_ready=0, ts_cur=1, done=0. After release, the first request is granted from rr pointer 0.
- Single read: req 1 reads sel=10, x=0, y=2; memory returns 0x5A -> mem_en at cycle 1, rsp_valid=0010 with rsp_data=0x5A exactly MEM_LAT cycles after mem_en.
- Round-robin: all four req_valid held -> grant order 0,1,2,3,0. Then with req 0 and req 3 held and the pointer at 1 -> grant 3 then 0.
- Write: req 3 writes sel=11, x=1, y=1, wdata=0x01 -> one mem_en with mem_we=1 and matching fields. No rsp_valid without WRITE_ACK_EN; one pulse on rsp_valid[3] with it.
- Timestep barrier: ts_adv_valid raised during a read -> mem_t_adv only after RESP, ts_cur 1->2. Repeat 10 advances -> done=1 at ts_cur=10, and the 11th ts_adv_valid is never acknowledged.
- MEM_LAT=1 build: read by req 0 -> RESP in the cycle directly after ISSUE, rsp_data equals mem_rdata.
